pixel_dispatcher: RTL and testbench
===================================

Name: pixel_dispatcher

Overview:
- Issues per-pixel work items (x, y, sof, eol) to the ray-tracing compute cores in strict round-robin, raster order.
- Sits upstream of the cores. Its issue order matches the in-order, round-robin collection on the output side, so core N receives every (no_of_extra_cores+1)-th pixel starting at pixel N.
- Each core has its own valid/ready handshake.
- Frame starts on a start pulse. A frame_done pulse marks acceptance of the last pixel.

Parameters:
- MAX_CORES, 2, number of core ports instantiated (1..2 supported).
- COORD_W, 13, width of image dimensions and coordinates.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- start  input  1  frame start request, sampled in IDLE only.
- image_width  input  COORD_W  pixels per row, sampled on accepted start.
- image_height  input  COORD_W  rows per frame, sampled on accepted start.
- no_of_extra_cores  input  3  active cores minus 1, sampled on accepted start.
- core_ready  input  MAX_CORES  per-core ready to accept a work item.
- core_valid  output  MAX_CORES  per-core work item valid.
- core_x  output  COORD_W  x coordinate of the current item; shared bus, qualified by core_valid.
- core_y  output  COORD_W  y coordinate of the current item.
- core_sof  output  1  current item is pixel (0,0).
- core_eol  output  1  current item is the last pixel of its row (x == width-1).
- busy  output  1  high from accepted start until frame_done.
- frame_done  output  1  one-cycle pulse after the last item is accepted.

Behaviour:
- Reset (areset=1 at a clock edge):
  - state goes to IDLE.
  - All outputs become 0: core_valid, core_x, core_y, core_sof, core_eol, busy, frame_done.
  - Internal x, y and core index are cleared.
  - Reset mid-frame aborts the frame. core_valid is low in the cycle after reset; no frame_done is generated.
- States:
  - IDLE: idle; all core_valid low.
  - ISSUE: one work item presented.
  - DONE: one cycle.
- IDLE -> ISSUE:
  - Condition: start=1, image_width != 0 and image_height != 0.
  - On this transition, latch the dimensions and active = min(no_of_extra_cores, MAX_CORES-1).
  - Set x=0, y=0, cur=0, busy=1.
  - start with a zero dimension is ignored: stay IDLE, busy stays 0.
- Latency: start accepted at edge N; core_valid[0] is high with x=0, y=0, sof=1 from cycle N+1.
- ISSUE:
  - Exactly one bit of core_valid is high: bit cur.
  - core_x, core_y, core_sof and core_eol are driven from registers and stay stable until handshake.
  - Handshake: core_valid[cur] && core_ready[cur] at a clock edge.
  - core_ready of non-selected cores is ignored.
  - Valid never drops without a handshake; no combinational ready->valid path.
- On handshake:
  - x advances: if x == width-1 then x=0 and y=y+1, else x=x+1.
  - cur advances: if cur == active then cur=0, else cur=cur+1.
  - If the item was (width-1, height-1), go to DONE instead; core_valid goes low next cycle.
  - Otherwise the next item is presented the following cycle, so throughput is at most one item per clock.
- DONE: frame_done=1 for one cycle, busy drops with it, then IDLE. start during DONE is ignored.
- start while busy is ignored. Input dimension and core-count changes mid-frame have no effect.
- Arithmetic: x and y are COORD_W unsigned. width*height is never computed; end of frame is detected from the coordinates.
- Widths of 1 are legal:
  - core_eol=1 on every item.
  - Width=1, height=1 frame: single item with sof=1 and eol=1, then DONE.
- no_of_extra_cores >= MAX_CORES clamps to MAX_CORES-1. With MAX_CORES=1, cur stays 0.

Optional Feature:
- Macro: PIXEL_DISPATCH_LOOP_EN.
- Defined:
  - DONE returns directly to ISSUE with x=0, y=0, cur=0 and sof=1, reusing the latched dimensions, so frames repeat continuously.
  - frame_done still pulses once per frame; busy stays high.
  - Holding start=0 has no effect. Only areset stops the loop.
- Not defined: DONE always returns to IDLE, as described in Behaviour.

Test Plan:
- Basic 2-core issue:
  - Stimulus: width=4, height=2, no_of_extra_cores=1, core_ready=2'b11, pulse start.
  - Required: 8 items over 8 consecutive cycles, alternating core0/core1.
  - Required coordinates: (0,0) sof on core0; (3,0) eol on core1; (3,1) eol on core1.
  - Required end: frame_done one cycle after the last handshake; busy low afterwards.
- Backpressure:
  - Stimulus: same frame, core1_ready held low for 5 cycles on item (1,0).
  - Required: core_valid[1], x=1, y=0 held stable for those 5 cycles; core0 is not issued; the sequence resumes in order.
- Single core and clamp:
  - Stimulus: no_of_extra_cores=5, MAX_CORES=2, width=3, height=1.
  - Required: issue order core0, core1, core0.
  - Stimulus: no_of_extra_cores=0.
  - Required: all 3 items go to core0.
- Degenerate sizes:
  - Stimulus: start with width=0 or height=0.
  - Required: busy stays 0 and no core_valid.
  - Stimulus: width=1, height=1.
  - Required: a single item (0,0) with sof=1 and eol=1, then frame_done.
- Reset and ignored start:
  - Stimulus: areset asserted mid-frame at item (2,1).
  - Required: core_valid=0 and busy=0 the next cycle; no frame_done.
  - Stimulus: start pulsed while busy.
  - Required: no effect on the sequence.
- PIXEL_DISPATCH_LOOP_EN:
  - Stimulus: width=2, height=2.
  - Required: after frame_done, item (0,0) with sof=1 is issued in the cycle after DONE; 3 frame_done pulses over 3 frames.

Source files
------------

// File: rtl/pixel_dispatcher_if.sv
// Work-item bus between the pixel dispatcher and the compute cores.
// One valid/ready pair per core; x, y, sof and eol are a shared bus that is
// qualified by whichever core_valid bit is high.
//   core_valid : dispatcher -> cores, per-core item valid (at most one bit high)
//   core_ready : cores -> dispatcher, per-core ready
//   core_x/y   : pixel coordinates of the presented item
//   core_sof   : item is pixel (0,0)
//   core_eol   : item is the last pixel of its row
interface pixel_dispatcher_if #(
  parameter int unsigned MAX_CORES = 2,
  parameter int unsigned COORD_W   = 13
);
  logic [MAX_CORES-1:0] core_valid;
  logic [MAX_CORES-1:0] core_ready;
  logic [COORD_W-1:0]   core_x;
  logic [COORD_W-1:0]   core_y;
  logic                 core_sof;
  logic                 core_eol;

  modport master (
    output core_valid,
    output core_x,
    output core_y,
    output core_sof,
    output core_eol,
    input  core_ready
  );

  modport slave (
    input  core_valid,
    input  core_x,
    input  core_y,
    input  core_sof,
    input  core_eol,
    output core_ready
  );
endinterface

// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: issues (x, y, sof, eol) work items to the compute cores in
// raster order and strict round-robin, so core N receives every
// (active+1)-th pixel starting at pixel N.
// Ports:
//   aclk, areset       : clock, synchronous active-high reset
//   start              : frame start request, honoured only when idle
//   image_width/height : frame size, latched on an accepted start
//   no_of_extra_cores  : active cores minus one, clamped to MAX_CORES-1
//   core_bus           : per-core valid/ready plus shared item bus (master side)
//   busy               : accepted start until frame_done
//   frame_done         : one-cycle pulse after the last item is accepted
// Optional build macro PIXEL_DISPATCH_LOOP_EN: frames repeat continuously with
// the latched dimensions until reset.
module pixel_dispatcher #(
  parameter int unsigned MAX_CORES = 2,
  parameter int unsigned COORD_W   = 13
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [COORD_W-1:0]    image_width,
  input  logic [COORD_W-1:0]    image_height,
  input  logic [2:0]            no_of_extra_cores,
  pixel_dispatcher_if.master    core_bus,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CurW = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e             state_q;
  logic [COORD_W-1:0] width_q;
  logic [COORD_W-1:0] height_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [CurW-1:0]    cur_q;
  logic [CurW-1:0]    active_q;

  logic [CurW-1:0]    active_clamp;
  logic [CurW-1:0]    cur_next;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               x_wrap;
  logic               last_item;
  logic               handshake;

  assign core_bus.core_x = x_q;
  assign core_bus.core_y = y_q;

  always_comb begin
    active_clamp = CurW'(no_of_extra_cores);
    if (32'(no_of_extra_cores) > MAX_CORES - 1) begin
      active_clamp = CurW'(MAX_CORES - 1);
    end
    x_wrap    = (x_q == width_q - COORD_W'(1));
    last_item = x_wrap && (y_q == height_q - COORD_W'(1));
    x_next    = x_wrap ? '0 : x_q + COORD_W'(1);
    y_next    = x_wrap ? y_q + COORD_W'(1) : y_q;
    cur_next  = (cur_q == active_q) ? '0 : cur_q + CurW'(1);
    // Only bit cur_q of core_valid is ever set, so the AND picks the selected
    // core's ready and ignores the others.
    handshake = (state_q == StIssue) && |(core_bus.core_valid & core_bus.core_ready);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q             <= StIdle;
      width_q             <= '0;
      height_q            <= '0;
      x_q                 <= '0;
      y_q                 <= '0;
      cur_q               <= '0;
      active_q            <= '0;
      core_bus.core_valid <= '0;
      core_bus.core_sof   <= 1'b0;
      core_bus.core_eol   <= 1'b0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && (image_width != '0) && (image_height != '0)) begin
            state_q             <= StIssue;
            width_q             <= image_width;
            height_q            <= image_height;
            active_q            <= active_clamp;
            x_q                 <= '0;
            y_q                 <= '0;
            cur_q               <= '0;
            core_bus.core_valid <= MAX_CORES'(1);
            core_bus.core_sof   <= 1'b1;
            core_bus.core_eol   <= (image_width == COORD_W'(1));
            busy                <= 1'b1;
          end
        end
        StIssue: begin
          if (handshake) begin
            if (last_item) begin
              state_q             <= StDone;
              core_bus.core_valid <= '0;
              frame_done          <= 1'b1;
`ifndef PIXEL_DISPATCH_LOOP_EN
              busy                <= 1'b0;
`endif
            end else begin
              x_q                 <= x_next;
              y_q                 <= y_next;
              cur_q               <= cur_next;
              core_bus.core_valid <= MAX_CORES'(1) << cur_next;
              core_bus.core_sof   <= 1'b0;
              core_bus.core_eol   <= (x_next == width_q - COORD_W'(1));
            end
          end
        end
        StDone: begin
`ifdef PIXEL_DISPATCH_LOOP_EN
          // Restart the same frame immediately from the latched dimensions.
          state_q             <= StIssue;
          x_q                 <= '0;
          y_q                 <= '0;
          cur_q               <= '0;
          core_bus.core_valid <= MAX_CORES'(1);
          core_bus.core_sof   <= 1'b1;
          core_bus.core_eol   <= (width_q == COORD_W'(1));
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher with a scoreboard of expected work items.
module tb_pixel_dispatcher;
  localparam int unsigned MaxCores = 2;
  localparam int unsigned CoordW   = 13;

  typedef struct {
    int core;
    int x;
    int y;
    bit sof;
    bit eol;
  } item_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              start = 1'b0;
  logic [CoordW-1:0] image_width = '0;
  logic [CoordW-1:0] image_height = '0;
  logic [2:0]        no_of_extra_cores = '0;
  logic              busy;
  logic              frame_done;

  pixel_dispatcher_if #(.MAX_CORES(MaxCores), .COORD_W(CoordW)) core_bus ();

  pixel_dispatcher #(.MAX_CORES(MaxCores), .COORD_W(CoordW)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .start             (start),
    .image_width       (image_width),
    .image_height      (image_height),
    .no_of_extra_cores (no_of_extra_cores),
    .core_bus          (core_bus),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 aclk = ~aclk;

  item_t             exp_q[$];
  int                checks = 0;
  int                passes = 0;
  int                cyc = 0;
  int                last_hs = -10;
  int                hs_count = 0;
  int                fd_count = 0;
  logic              prev_pending = 1'b0;
  logic [MaxCores-1:0] prev_valid = '0;
  logic [CoordW-1:0] prev_x = '0;
  logic [CoordW-1:0] prev_y = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected item stream of one frame, raster order, round-robin over active cores.
  task automatic push_frame(input int w, input int h, input int noc);
    int act;
    int n;
    act = (noc > MaxCores - 1) ? MaxCores - 1 : noc;
    n = 0;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        exp_q.push_back('{core: n % (act + 1), x: xx, y: yy,
                          sof: (xx == 0 && yy == 0), eol: (xx == w - 1)});
        n++;
      end
    end
  endtask

  // One clock: monitor at the falling edge, then step past the rising edge.
  task automatic cycle();
    item_t e;
    logic [MaxCores-1:0] hs;
    @(negedge aclk);
    hs = core_bus.core_valid & core_bus.core_ready;
    if (core_bus.core_valid != '0) begin
      check("valid_onehot", 32'($countones(core_bus.core_valid)), 32'(1));
    end
    if (prev_pending) begin
      check("hold_valid", 32'(core_bus.core_valid), 32'(prev_valid));
      check("hold_x", 32'(core_bus.core_x), 32'(prev_x));
      check("hold_y", 32'(core_bus.core_y), 32'(prev_y));
    end
    if (frame_done) begin
      fd_count++;
      check("fd_after_last_hs", 32'(cyc), 32'(last_hs + 1));
`ifndef PIXEL_DISPATCH_LOOP_EN
      check("fd_busy_low", 32'(busy), 32'(0));
`else
      check("fd_busy_high", 32'(busy), 32'(1));
`endif
      check("fd_valid_low", 32'(core_bus.core_valid), 32'(0));
    end
    if (hs != '0) begin
      check("sb_has_item", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("item_core", 32'(core_bus.core_valid), 32'(1) << e.core);
        check("item_x", 32'(core_bus.core_x), 32'(e.x));
        check("item_y", 32'(core_bus.core_y), 32'(e.y));
        check("item_sof", 32'(core_bus.core_sof), 32'(e.sof));
        check("item_eol", 32'(core_bus.core_eol), 32'(e.eol));
      end
      last_hs = cyc;
      hs_count++;
    end
    prev_pending = (core_bus.core_valid != '0) && (hs == '0) && !areset;
    prev_valid   = core_bus.core_valid;
    prev_x       = core_bus.core_x;
    prev_y       = core_bus.core_y;
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic start_frame(input int w, input int h, input int noc);
    image_width       = CoordW'(w);
    image_height      = CoordW'(h);
    no_of_extra_cores = 3'(noc);
    push_frame(w, h, noc);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int fd0;
    int n;
    fd0 = fd_count;
    n = 0;
    while (fd_count == fd0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_done_seen"}, 32'(fd_count != fd0), 32'(1));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_valid"}, 32'(core_bus.core_valid), 32'(0));
      cycle();
    end
  endtask

  initial begin
    int s_cyc;
    int hs0;
    int fd0;
    bit found;
    core_bus.core_ready = '1;
    areset = 1'b1;
    cycle();
    cycle();
    check("rst_valid", 32'(core_bus.core_valid), 32'(0));
    check("rst_x", 32'(core_bus.core_x), 32'(0));
    check("rst_y", 32'(core_bus.core_y), 32'(0));
    check("rst_sof", 32'(core_bus.core_sof), 32'(0));
    check("rst_eol", 32'(core_bus.core_eol), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_fd", 32'(frame_done), 32'(0));
    areset = 1'b0;
    cycle();

`ifndef PIXEL_DISPATCH_LOOP_EN
    // Basic 4x2 frame on two cores, full throughput.
    hs0 = hs_count;
    start_frame(4, 2, 1);
    s_cyc = cyc;
    check("lat_valid", 32'(core_bus.core_valid), 32'(1));
    check("lat_sof", 32'(core_bus.core_sof), 32'(1));
    check("lat_busy", 32'(busy), 32'(1));
    run_frame("basic", 40);
    check("basic_items", 32'(hs_count - hs0), 32'(8));
    check("basic_span", 32'(last_hs - s_cyc), 32'(7));
    check("basic_busy_after", 32'(busy), 32'(0));
    idle_cycles("basic_idle", 2);

    // Core1 stalls on item (1,0) for 5 cycles while core0 stays ready.
    core_bus.core_ready = 2'b01;
    start_frame(4, 2, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(core_bus.core_valid), 32'(2));
      check("bp_x", 32'(core_bus.core_x), 32'(1));
      check("bp_y", 32'(core_bus.core_y), 32'(0));
      cycle();
    end
    core_bus.core_ready = 2'b11;
    run_frame("bp", 40);

    // Clamp of extra cores, then single core with a start pulsed while busy.
    start_frame(3, 1, 5);
    run_frame("clamp", 20);
    start_frame(3, 1, 0);
    start = 1'b1;
    image_width = 13'd7;
    no_of_extra_cores = 3'd1;
    cycle();
    start = 1'b0;
    run_frame("single", 20);
    idle_cycles("post_single", 2);

    // Zero dimensions are ignored.
    image_width = 13'd0;
    image_height = 13'd3;
    start = 1'b1;
    cycle();
    start = 1'b0;
    idle_cycles("zero_w", 3);
    image_width = 13'd3;
    image_height = 13'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    idle_cycles("zero_h", 3);

    // Width-1 frames: every item is end-of-line.
    start_frame(1, 1, 1);
    run_frame("one_by_one", 10);
    start_frame(1, 3, 1);
    run_frame("one_by_three", 20);

    // Reset in the middle of a frame at item (2,1).
    start_frame(4, 3, 1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (core_bus.core_valid != '0 && core_bus.core_x == 13'd2 && core_bus.core_y == 13'd1) begin
        found = 1'b1;
      end else begin
        cycle();
      end
    end
    check("mid_found", 32'(found), 32'(1));
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    check("mid_rst_valid", 32'(core_bus.core_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    exp_q.delete();
    fd0 = fd_count;
    idle_cycles("mid_rst_idle", 5);
    check("mid_rst_no_fd", 32'(fd_count), 32'(fd0));
`else
    // Looping frames: three back-to-back 2x2 frames.
    push_frame(2, 2, 1);
    push_frame(2, 2, 1);
    start_frame(2, 2, 1);
    fd0 = fd_count;
    for (int i = 0; i < 60 && (fd_count - fd0) < 3; i++) begin
      check("loop_busy", 32'(busy), 32'(1));
      cycle();
    end
    check("loop_fd_count", 32'(fd_count - fd0), 32'(3));
    check("loop_restart_valid", 32'(core_bus.core_valid), 32'(1));
    check("loop_restart_sof", 32'(core_bus.core_sof), 32'(1));
    check("loop_restart_x", 32'(core_bus.core_x), 32'(0));
    check("loop_restart_y", 32'(core_bus.core_y), 32'(0));
    core_bus.core_ready = '0;
    start = 1'b0;
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    core_bus.core_ready = '1;
    exp_q.delete();
    idle_cycles("loop_stopped", 3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
